// File: rtl/wb_pkg.sv
// ---------------------------------------------------------------------------
// wb_pkg
//   Shared definitions for the writeback arbiter and its result FIFOs.
//   - NUM_WB_PORTS : number of register-file write ports being arbitrated.
//   - DEFAULT_*    : default widths/sizes used by the arbiter and FIFO.
//   - fu_idx_width : width of an index that can name any of num_fu units.
// ---------------------------------------------------------------------------
package wb_pkg;

  localparam int NUM_WB_PORTS       = 3;
  localparam int DEFAULT_TAG_WIDTH  = 6;
  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_NUM_FU     = 4;
  localparam int DEFAULT_FIFO_DEPTH = 2;

  // Index width for num_fu units; a single unit still needs one bit.
  function automatic int fu_idx_width(input int num_fu);
    return (num_fu > 1) ? $clog2(num_fu) : 1;
  endfunction

endpackage

// File: rtl/wb_result_fifo.sv
// ---------------------------------------------------------------------------
// wb_result_fifo
//   Small per-FU result buffer holding {tag, data} pairs in push order.
//   Ports:
//     clk, rst            clock, asynchronous active-high reset
//     push, push_tag,     write a new result (ignored while full, even if
//     push_data           a pop happens in the same cycle)
//     pop                 retire the head entry (ignored while empty)
//     head_tag, head_data oldest entry, valid whenever !empty
//     empty, full         occupancy flags (full means count == FIFO_DEPTH)
// ---------------------------------------------------------------------------
module wb_result_fifo
  import wb_pkg::*;
#(
  parameter int TAG_WIDTH  = DEFAULT_TAG_WIDTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [TAG_WIDTH-1:0]  push_tag,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [TAG_WIDTH-1:0]  head_tag,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic                  empty,
  output logic                  full
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [TAG_WIDTH-1:0]  tag_mem  [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] data_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  logic [CNT_W-1:0]      count;
  logic                  do_push;
  logic                  do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(FIFO_DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  assign head_tag  = tag_mem[rd_ptr];
  assign head_data = data_mem[rd_ptr];

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the pre-edge value of every other flop, independent of
  // process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array is deliberately not reset; count/pointers define
  // which entries are valid, and leaving the array reset-free lets it map to
  // plain flops or RAM without a reset tree.
  always_ff @(posedge clk) begin
    if (do_push) begin
      tag_mem[wr_ptr]  <= push_tag;
      data_mem[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// ---------------------------------------------------------------------------
// wb_port_arbiter
//   Writeback arbiter between NUM_FU execution units and the three write
//   ports of the physical register file. Each FU feeds a small result FIFO;
//   each cycle up to three FIFO heads with mutually distinct tags are granted
//   in round-robin order starting at rr_ptr, and the grants are registered
//   onto the write ports on the same edge that pops the FIFOs.
//   Ports:
//     clk, rst                    clock, asynchronous active-high reset
//     fu_valid_i / fu_ready_o     per-FU push handshake
//     fu_tag_i / fu_data_i        per-FU result, FU i at [i*W +: W]
//     wb_stall_i                  suppresses all grants and pops
//     wrN_en_o/tag_o/data_o       registered write port N (1..3); tag and
//                                 data hold their value while en is low
// ---------------------------------------------------------------------------
module wb_port_arbiter
  import wb_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int TAG_WIDTH  = DEFAULT_TAG_WIDTH,
  parameter int NUM_FU     = DEFAULT_NUM_FU,
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_FU-1:0]            fu_valid_i,
  output logic [NUM_FU-1:0]            fu_ready_o,
  input  logic [NUM_FU*TAG_WIDTH-1:0]  fu_tag_i,
  input  logic [NUM_FU*DATA_WIDTH-1:0] fu_data_i,
  input  logic                         wb_stall_i,
  output logic                         wr1_en_o,
  output logic [TAG_WIDTH-1:0]         wr1_tag_o,
  output logic [DATA_WIDTH-1:0]        wr1_data_o,
  output logic                         wr2_en_o,
  output logic [TAG_WIDTH-1:0]         wr2_tag_o,
  output logic [DATA_WIDTH-1:0]        wr2_data_o,
  output logic                         wr3_en_o,
  output logic [TAG_WIDTH-1:0]         wr3_tag_o,
  output logic [DATA_WIDTH-1:0]        wr3_data_o
);

  localparam int FU_W = fu_idx_width(NUM_FU);

  // ---------------------------------------------------------------------
  // Per-FU result FIFOs
  // ---------------------------------------------------------------------
  logic [NUM_FU-1:0]     fifo_push;
  logic [NUM_FU-1:0]     fifo_pop;
  logic [NUM_FU-1:0]     fifo_empty;
  logic [NUM_FU-1:0]     fifo_full;
  logic [TAG_WIDTH-1:0]  head_tag  [NUM_FU];
  logic [DATA_WIDTH-1:0] head_data [NUM_FU];

  // Ready depends only on occupancy, never on this cycle's grant, so a full
  // FIFO refuses a push even in the cycle it is popped.
  assign fu_ready_o = ~fifo_full & {NUM_FU{~rst}};
  assign fifo_push  = fu_valid_i & fu_ready_o;

  for (genvar g = 0; g < NUM_FU; g++) begin : g_fifo
    wb_result_fifo #(
      .TAG_WIDTH  (TAG_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (fifo_push[g]),
      .push_tag  (fu_tag_i[g*TAG_WIDTH +: TAG_WIDTH]),
      .push_data (fu_data_i[g*DATA_WIDTH +: DATA_WIDTH]),
      .pop       (fifo_pop[g]),
      .head_tag  (head_tag[g]),
      .head_data (head_data[g]),
      .empty     (fifo_empty[g]),
      .full      (fifo_full[g])
    );
  end

  // ---------------------------------------------------------------------
  // Round-robin 3-grant selector with tag-collision masking
  // ---------------------------------------------------------------------
  logic [FU_W-1:0]       rr_ptr;
  logic [FU_W-1:0]       rr_ptr_next;
  logic                  gnt_en   [NUM_WB_PORTS];
  logic [TAG_WIDTH-1:0]  gnt_tag  [NUM_WB_PORTS];
  logic [DATA_WIDTH-1:0] gnt_data [NUM_WB_PORTS];

  // Heads are visited in rotated order rr_ptr, rr_ptr+1, ... and assigned to
  // the next free port, so port 1 always carries the earliest-scanned grant.
  // A head whose tag already went out this cycle is skipped, not blocking
  // the heads scanned after it.
  always_comb begin
    int  idx;
    int  n_gnt;
    logic hit;

    // NOTE: every output of this block gets a default before any conditional
    // logic, which keeps it purely combinational (no inferred latches).
    fifo_pop    = '0;
    rr_ptr_next = rr_ptr;
    for (int p = 0; p < NUM_WB_PORTS; p++) begin
      gnt_en[p]   = 1'b0;
      gnt_tag[p]  = '0;
      gnt_data[p] = '0;
    end
    idx   = 0;
    n_gnt = 0;
    hit   = 1'b0;

    if (!wb_stall_i) begin
      for (int k = 0; k < NUM_FU; k++) begin
        idx = int'(rr_ptr) + k;
        if (idx >= NUM_FU) begin
          idx = idx - NUM_FU;
        end

        hit = 1'b0;
        for (int p = 0; p < NUM_WB_PORTS; p++) begin
          if (p < n_gnt && gnt_tag[p] == head_tag[idx]) begin
            hit = 1'b1;
          end
        end

        if (!fifo_empty[idx] && n_gnt < NUM_WB_PORTS && !hit) begin
          for (int p = 0; p < NUM_WB_PORTS; p++) begin
            if (p == n_gnt) begin
              gnt_en[p]   = 1'b1;
              gnt_tag[p]  = head_tag[idx];
              gnt_data[p] = head_data[idx];
            end
          end
          fifo_pop[idx] = 1'b1;
          // Later grants overwrite this, leaving rr_ptr one past the last
          // FU granted in scan order.
          rr_ptr_next   = (idx == NUM_FU - 1) ? '0 : FU_W'(idx + 1);
          n_gnt         = n_gnt + 1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // rr_ptr and registered write ports
  // ---------------------------------------------------------------------
  logic                  wr_en_q   [NUM_WB_PORTS];
  logic [TAG_WIDTH-1:0]  wr_tag_q  [NUM_WB_PORTS];
  logic [DATA_WIDTH-1:0] wr_data_q [NUM_WB_PORTS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
      for (int p = 0; p < NUM_WB_PORTS; p++) begin
        wr_en_q[p]   <= 1'b0;
        wr_tag_q[p]  <= '0;
        wr_data_q[p] <= '0;
      end
    end else begin
      rr_ptr <= rr_ptr_next;
      for (int p = 0; p < NUM_WB_PORTS; p++) begin
        wr_en_q[p] <= gnt_en[p];
        // Tag/data only move on a grant; while en is low they hold.
        if (gnt_en[p]) begin
          wr_tag_q[p]  <= gnt_tag[p];
          wr_data_q[p] <= gnt_data[p];
        end
      end
    end
  end

  assign wr1_en_o   = wr_en_q[0];
  assign wr1_tag_o  = wr_tag_q[0];
  assign wr1_data_o = wr_data_q[0];
  assign wr2_en_o   = wr_en_q[1];
  assign wr2_tag_o  = wr_tag_q[1];
  assign wr2_data_o = wr_data_q[1];
  assign wr3_en_o   = wr_en_q[2];
  assign wr3_tag_o  = wr_tag_q[2];
  assign wr3_data_o = wr_data_q[2];

endmodule

// File: tb/tb_wb_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wb_port_arbiter
//   Directed bench for wb_port_arbiter. A queue-level model tracks what each
//   FU buffer holds and which heads must be written each cycle; a negedge
//   compare process checks the DUT against it, and each scenario also pins
//   a few hand-computed values.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_wb_port_arbiter;

  localparam int DW = 32;
  localparam int TW = 6;
  localparam int NF = 4;
  localparam int FD = 2;
  localparam int NP = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NF-1:0]   fu_valid_i = '0;
  logic [NF-1:0]   fu_ready_o;
  logic [NF*TW-1:0] fu_tag_i = '0;
  logic [NF*DW-1:0] fu_data_i = '0;
  logic            wb_stall_i = 1'b0;
  logic            wr1_en_o, wr2_en_o, wr3_en_o;
  logic [TW-1:0]   wr1_tag_o, wr2_tag_o, wr3_tag_o;
  logic [DW-1:0]   wr1_data_o, wr2_data_o, wr3_data_o;

  wb_port_arbiter #(
    .DATA_WIDTH (DW),
    .TAG_WIDTH  (TW),
    .NUM_FU     (NF),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .fu_valid_i (fu_valid_i),
    .fu_ready_o (fu_ready_o),
    .fu_tag_i   (fu_tag_i),
    .fu_data_i  (fu_data_i),
    .wb_stall_i (wb_stall_i),
    .wr1_en_o   (wr1_en_o),
    .wr1_tag_o  (wr1_tag_o),
    .wr1_data_o (wr1_data_o),
    .wr2_en_o   (wr2_en_o),
    .wr2_tag_o  (wr2_tag_o),
    .wr2_data_o (wr2_data_o),
    .wr3_en_o   (wr3_en_o),
    .wr3_tag_o  (wr3_tag_o),
    .wr3_data_o (wr3_data_o)
  );

  always #5 clk = ~clk;

  logic          dut_en   [NP];
  logic [TW-1:0] dut_tag  [NP];
  logic [DW-1:0] dut_data [NP];
  assign dut_en[0] = wr1_en_o;  assign dut_tag[0] = wr1_tag_o;  assign dut_data[0] = wr1_data_o;
  assign dut_en[1] = wr2_en_o;  assign dut_tag[1] = wr2_tag_o;  assign dut_data[1] = wr2_data_o;
  assign dut_en[2] = wr3_en_o;  assign dut_tag[2] = wr3_tag_o;  assign dut_data[2] = wr3_data_o;

  int n_cmp  = 0;
  int n_fail = 0;
  logic chk_on = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // -------------------------------------------------------------------
  // Model: per-FU buffers as arrays with head at index 0
  // -------------------------------------------------------------------
  logic [TW-1:0] mq_tag  [NF][FD];
  logic [DW-1:0] mq_data [NF][FD];
  int            mcnt    [NF];
  int            m_rr;
  logic          exp_en   [NP];
  logic [TW-1:0] exp_tag  [NP];
  logic [DW-1:0] exp_data [NP];

  task automatic model_reset();
    for (int f = 0; f < NF; f++) mcnt[f] = 0;
    m_rr = 0;
    for (int p = 0; p < NP; p++) begin
      exp_en[p]   = 1'b0;
      exp_tag[p]  = '0;
      exp_data[p] = '0;
    end
  endtask

  // Advance the model over one clock edge using the inputs currently driven.
  task automatic model_step();
    logic acc [NF];
    logic gnt [NF];
    int   n;
    int   last;
    int   f;
    logic hit;
    for (int i = 0; i < NF; i++) begin
      acc[i] = fu_valid_i[i] && (mcnt[i] < FD);
      gnt[i] = 1'b0;
    end
    for (int p = 0; p < NP; p++) exp_en[p] = 1'b0;
    n = 0;
    last = -1;
    if (!wb_stall_i) begin
      for (int k = 0; k < NF; k++) begin
        f = (m_rr + k) % NF;
        if (mcnt[f] > 0 && n < NP) begin
          hit = 1'b0;
          for (int j = 0; j < n; j++) if (exp_tag[j] == mq_tag[f][0]) hit = 1'b1;
          if (!hit) begin
            exp_en[n]   = 1'b1;
            exp_tag[n]  = mq_tag[f][0];
            exp_data[n] = mq_data[f][0];
            gnt[f] = 1'b1;
            last = f;
            n++;
          end
        end
      end
    end
    if (n > 0) m_rr = (last + 1) % NF;
    for (int i = 0; i < NF; i++) begin
      if (gnt[i]) begin
        for (int s = 0; s < FD - 1; s++) begin
          mq_tag[i][s]  = mq_tag[i][s+1];
          mq_data[i][s] = mq_data[i][s+1];
        end
        mcnt[i]--;
      end
    end
    for (int i = 0; i < NF; i++) begin
      if (acc[i]) begin
        mq_tag[i][mcnt[i]]  = fu_tag_i[i*TW +: TW];
        mq_data[i][mcnt[i]] = fu_data_i[i*DW +: DW];
        mcnt[i]++;
      end
    end
  endtask

  function automatic logic [NF-1:0] model_ready();
    logic [NF-1:0] r;
    for (int f = 0; f < NF; f++) r[f] = (mcnt[f] < FD);
    return r;
  endfunction

  // -------------------------------------------------------------------
  // Compare process: every negedge, DUT outputs against the model
  // -------------------------------------------------------------------
  always @(negedge clk) begin
    if (chk_on) begin
      if (rst) begin
        check("rst_ready", 64'(fu_ready_o), 64'h0);
        for (int p = 0; p < NP; p++) check($sformatf("rst_wr%0d_en", p+1), 64'(dut_en[p]), 64'h0);
      end else begin
        check("ready", 64'(fu_ready_o), 64'(model_ready()));
        for (int p = 0; p < NP; p++) begin
          check($sformatf("wr%0d_en", p+1), 64'(dut_en[p]), 64'(exp_en[p]));
          if (exp_en[p]) begin
            check($sformatf("wr%0d_tag", p+1), 64'(dut_tag[p]), 64'(exp_tag[p]));
            check($sformatf("wr%0d_data", p+1), 64'(dut_data[p]), 64'(exp_data[p]));
          end
        end
      end
    end
  end

  // -------------------------------------------------------------------
  // Stimulus helpers; all called just after a negedge
  // -------------------------------------------------------------------
  task automatic set_fu(input int f, input logic [TW-1:0] tag, input logic [DW-1:0] data);
    fu_tag_i[f*TW +: TW]  = tag;
    fu_data_i[f*DW +: DW] = data;
  endtask

  task automatic cycle(input logic [NF-1:0] v, input logic stall);
    fu_valid_i = v;
    wb_stall_i = stall;
    model_step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    fu_valid_i = '0;
    wb_stall_i = 1'b0;
    rst = 1'b1;
    model_reset();
    #1;
    check("rst_imm_ready", 64'(fu_ready_o), 64'h0);
    check("rst_imm_en", 64'({wr3_en_o, wr2_en_o, wr1_en_o}), 64'h0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("rel_ready", 64'(fu_ready_o), 64'hF);
  endtask

  int gcnt [NF];
  int miss [NF];
  int maxmiss;

  initial begin
    chk_on = 1'b1;
    @(negedge clk);
    #1;
    do_reset();

    // Reset in the middle of traffic
    for (int f = 0; f < NF; f++) set_fu(f, TW'(1 + f), DW'(32'h100 + f));
    cycle(4'b1111, 1'b0);
    cycle(4'b1111, 1'b0);
    check("pre_rst_traffic", 64'(wr1_en_o), 64'h1);
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(4'b0000, 1'b0);
      check("post_rst_no_write", 64'({wr3_en_o, wr2_en_o, wr1_en_o}), 64'h0);
    end

    // Single result: push on edge 1, visible after edge 2
    do_reset();
    set_fu(0, 6'd5, 32'hDEADBEEF);
    cycle(4'b0001, 1'b0);
    check("no_bypass", 64'(wr1_en_o), 64'h0);
    cycle(4'b0000, 1'b0);
    check("single_en1", 64'(wr1_en_o), 64'h1);
    check("single_tag", 64'(wr1_tag_o), 64'd5);
    check("single_data", 64'(wr1_data_o), 64'hDEADBEEF);
    check("single_en23", 64'({wr3_en_o, wr2_en_o}), 64'h0);
    check("single_rr", 64'(m_rr), 64'd1);

    // Four-way contention from rr_ptr = 0
    do_reset();
    for (int f = 0; f < NF; f++) set_fu(f, TW'(1 + f), DW'(32'h10 + f));
    cycle(4'b1111, 1'b0);
    cycle(4'b0000, 1'b0);
    check("four_en", 64'({wr3_en_o, wr2_en_o, wr1_en_o}), 64'h7);
    check("four_tags", 64'({wr1_tag_o, wr2_tag_o, wr3_tag_o}), 64'({6'd1, 6'd2, 6'd3}));
    check("four_rr_a", 64'(m_rr), 64'd3);
    cycle(4'b0000, 1'b0);
    check("four_second", 64'({wr3_en_o, wr2_en_o, wr1_en_o}), 64'h1);
    check("four_second_tag", 64'(wr1_tag_o), 64'd4);
    check("four_rr_b", 64'(m_rr), 64'd0);
    cycle(4'b0000, 1'b0);

    // Tag collision: FU0 and FU2 share tag 9
    do_reset();
    set_fu(0, 6'd9, 32'h900);
    set_fu(1, 6'd10, 32'hA01);
    set_fu(2, 6'd9, 32'h902);
    cycle(4'b0111, 1'b0);
    cycle(4'b0000, 1'b0);
    check("coll_en", 64'({wr3_en_o, wr2_en_o, wr1_en_o}), 64'h3);
    check("coll_p1", 64'({wr1_tag_o, wr1_data_o}), 64'({6'd9, 32'h900}));
    check("coll_p2", 64'({wr2_tag_o, wr2_data_o}), 64'({6'd10, 32'hA01}));
    cycle(4'b0000, 1'b0);
    check("coll_late_en", 64'({wr3_en_o, wr2_en_o, wr1_en_o}), 64'h1);
    check("coll_late_p1", 64'({wr1_tag_o, wr1_data_o}), 64'({6'd9, 32'h902}));

    // Backpressure under stall with FU1 filling its buffer
    do_reset();
    set_fu(1, 6'd20, 32'hA);
    cycle(4'b0010, 1'b1);
    set_fu(1, 6'd21, 32'hB);
    cycle(4'b0010, 1'b1);
    check("bp_full", 64'(fu_ready_o), 64'hD);
    set_fu(1, 6'd22, 32'hC);
    cycle(4'b0010, 1'b1);
    cycle(4'b0010, 1'b1);
    check("bp_held", 64'({fu_ready_o, wr3_en_o, wr2_en_o, wr1_en_o}), 64'({4'hD, 3'b000}));
    cycle(4'b0010, 1'b0);
    check("bp_out_a", 64'({wr1_en_o, wr1_data_o}), 64'({1'b1, 32'hA}));
    check("bp_ready_back", 64'(fu_ready_o), 64'hF);
    cycle(4'b0010, 1'b0);
    check("bp_out_b", 64'({wr1_en_o, wr1_data_o}), 64'({1'b1, 32'hB}));
    cycle(4'b0000, 1'b0);
    check("bp_out_c", 64'({wr1_en_o, wr1_data_o}), 64'({1'b1, 32'hC}));
    cycle(4'b0000, 1'b0);

    // Round-robin fairness over 8 output cycles
    do_reset();
    for (int f = 0; f < NF; f++) begin
      set_fu(f, TW'(30 + f), {4'(f), 28'd0});
      gcnt[f] = 0;
      miss[f] = 0;
    end
    maxmiss = 0;
    cycle(4'b1111, 1'b0);
    for (int c = 0; c < 8; c++) begin
      for (int f = 0; f < NF; f++) set_fu(f, TW'(30 + f), {4'(f), 28'(c + 1)});
      cycle(4'b1111, 1'b0);
      for (int f = 0; f < NF; f++) begin
        logic got;
        got = 1'b0;
        for (int p = 0; p < NP; p++) if (dut_en[p] && int'(dut_data[p][31:28]) == f) got = 1'b1;
        if (got) begin
          gcnt[f]++;
          miss[f] = 0;
        end else begin
          miss[f]++;
          if (miss[f] > maxmiss) maxmiss = miss[f];
        end
      end
    end
    for (int f = 0; f < NF; f++) check($sformatf("fair_fu%0d", f), 64'(gcnt[f]), 64'd6);
    check("fair_starve", 64'(maxmiss), 64'd1);
    check("fair_rr", 64'(m_rr), 64'd0);
    for (int i = 0; i < 4; i++) cycle(4'b0000, 1'b0);

    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Writeback arbiter between the execution units and the 3-write-port physical register file of the out-of-order core. It buffers results from NUM_FU functional units in small per-unit FIFOs. Each cycle it grants up to three distinct-tag results to the register file's three write ports using round-robin priority. The outputs are registered and drive the register file's per-port write-enable/tag/data directly.

## Interface
- DATA_WIDTH, 32: result data width
- TAG_WIDTH, 6: physical register tag width
- NUM_FU, 4: number of producing execution units (≥3)
- FIFO_DEPTH, 2: per-FU result buffer depth (power of two)

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- fu_valid_i  in  NUM_FU  result valid, one bit per FU
- fu_ready_o  out  NUM_FU  FU buffer can accept
- fu_tag_i  in  NUM_FU*TAG_WIDTH  destination tag, FU i at bits [i*TAG_WIDTH +: TAG_WIDTH]
- fu_data_i  in  NUM_FU*DATA_WIDTH  result data, same packing
- wb_stall_i  in  1  downstream stall; no grants while high
- wr1_en_o / wr2_en_o / wr3_en_o  out  1  write enable, ports 1..3
- wr1_tag_o / wr2_tag_o / wr3_tag_o  out  TAG_WIDTH  write tag
- wr1_data_o / wr2_data_o / wr3_data_o  out  DATA_WIDTH  write data

## Operation
- Per-FU FIFO:
  - Push when fu_valid_i[i] & fu_ready_o[i].
  - fu_ready_o[i] = !full[i] & !rst. It is a function of FIFO count only, never of the current-cycle grant.
  - A full FIFO does not accept even in a cycle it pops.
- Grant:
  - Only FIFO heads are eligible, at most one grant per FU per cycle.
  - Scan FUs from rr_ptr upward, wrapping. The first eligible head goes to port 1, the second to port 2, the third to port 3.
  - A head whose tag equals a tag already granted this cycle is skipped and waits. The lowest-numbered port always holds the earliest-scanned grant.
  - Unused ports have en=0.
  - wb_stall_i=1: no grants, no pops, and all wr*_en_o are 0 next cycle.
- Pop occurs on the same edge that registers the grant onto the port outputs.
- rr_ptr:
  - After a cycle with ≥1 grant, rr_ptr <= (last granted FU index + 1) mod NUM_FU.
  - With no grants, rr_ptr is unchanged.
- Port outputs:
  - Registered every cycle.
  - When en=0, tag and data hold their previous value. Only en is meaningful.
- Ordering: results from one FU leave in push order. Different FUs are not ordered.

## Timing
- Reset (asynchronous, immediate):
  - All FIFOs empty, rr_ptr=0.
  - wr*_en_o=0, wr*_tag_o=0, wr*_data_o=0.
  - fu_ready_o=0 while rst is high, and all 1 in the first cycle after release.
- Latency:
  - A result pushed at edge k is the head from edge k (if its FIFO was empty), is granted combinationally, and appears with wrN_en_o=1 after edge k+1.
  - Minimum latency is 2 edges from handshake to port valid. There is no bypass.
- Throughput: 3 results/cycle maximum, 1 per FU per cycle.
- Full condition: count==FIFO_DEPTH. fu_ready_o drops the cycle after the filling push.
- Stall release: grants resume in the first cycle with wb_stall_i=0, and ports are valid after the next edge.
- Reset mid-operation discards all buffered and in-flight results. No partial writes are emitted after reset is released.

## Structure
- Shared package/header `wb_pkg`:
  - localparam NUM_WB_PORTS=3
  - tag/data width defaults
  - FU index width clog2(NUM_FU)
- Sub-module `wb_result_fifo`:
  - Parameters TAG_WIDTH, DATA_WIDTH, FIFO_DEPTH.
  - Push/pop, head tag/data, empty/full, asynchronous reset.
  - Instantiated NUM_FU times.
- Top level contains the round-robin 3-grant selector with tag-collision masking, rr_ptr, and the output registers.

## Test plan
- Reset: assert rst mid-traffic → all wr*_en_o=0 immediately, fu_ready_o=0000. Release → fu_ready_o=1111, no writes appear.
- Single result: FU0 pushes tag 5, data 0xDEADBEEF at edge 1 → after edge 2, wr1_en_o=1, tag 5, data 0xDEADBEEF, wr2/wr3_en_o=0. rr_ptr=1.
- Four-way contention from rr_ptr=0: FU0..3 push tags 1,2,3,4 together → next grant puts FU0/FU1/FU2 on ports 1/2/3 and sets rr_ptr=3. The following cycle puts FU3 on port 1 and sets rr_ptr=0.
- Tag collision: FU0 and FU2 both tag 9, FU1 tag 10 → first grant has port1=FU0 (tag 9) and port2=FU1 (tag 10). FU2's tag 9 goes out alone on port 1 the next cycle.
- Backpressure: hold wb_stall_i=1, FU1 pushes 0xA, 0xB (FIFO_DEPTH=2) → fu_ready_o[1]=0, a third valid is held. Drop the stall → 0xA then 0xB on port 1 in consecutive cycles, ready returns, third push is accepted.
- Round-robin fairness: all FUs continuously valid with distinct tags for 8 cycles → each FU receives exactly 6 grants (3/cycle ×8 /4), no FU starved more than 1 cycle.
